// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared add/multiply scheduler.
// Holds the opcode values, the FSM state encoding and the fixed widths.
package alu_share_pkg;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int DATA_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_sched_rr_pick.sv
// Combinational round-robin picker: the first set request after ptr wins.
// Produces both a one-hot grant vector and the encoded winner id.
module rr_pick
  import alu_share_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  id
);

  // rot[k] is the request of requester ptr+1+k (mod 4), so rot[0] has top priority
  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;
  logic             found;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req[ptr + ID_W'(gi + 1)];
    end
  endgenerate

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        off   = ID_W'(k);
        found = 1'b1;
      end
    end
    id     = found ? (ptr + off + ID_W'(1)) : '0;
    onehot = found ? (N_REQ'(1) << id) : '0;
  end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one add/multiply datapath among four requesters with round-robin
// arbitration, latched operands and a tagged, pulsed result.
module alu_share_sched
  import alu_share_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        op,
  input  logic [N_REQ*DATA_W-1:0] a_bus,
  input  logic [N_REQ*DATA_W-1:0] b_bus,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic [2*DATA_W-1:0]     result,
  output logic                    done,
  output logic [ID_W-1:0]         done_id
);

  localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [ID_W-1:0]     id_reg, id_next;
  logic                op_reg, op_next;
  logic [DATA_W-1:0]   a_reg, a_next;
  logic [DATA_W-1:0]   b_reg, b_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [N_REQ-1:0]    grant_reg, grant_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic [ID_W-1:0]     done_id_reg, done_id_next;

  logic [N_REQ-1:0]    pick_onehot;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     sel;
  logic [DATA_W-1:0]   mux_a, mux_b;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .id     (pick_id)
  );

  // Operand mux follows the picker while idle and the latched owner otherwise
  assign sel   = (state_reg == ST_IDLE) ? pick_id : id_reg;
  assign mux_a = a_bus[sel*DATA_W +: DATA_W];
  assign mux_b = b_bus[sel*DATA_W +: DATA_W];
  assign sum   = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod  = a_reg * b_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= ID_W'(N_REQ - 1);
      id_reg      <= '0;
      op_reg      <= OP_ADD;
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      done_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      id_reg      <= id_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      cnt_reg     <= cnt_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      result_reg  <= result_next;
      done_id_reg <= done_id_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    id_next      = id_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    cnt_next     = cnt_reg;
    grant_next   = '0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    result_next  = result_reg;
    done_id_next = done_id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          state_next = ST_EXEC;
          id_next    = pick_id;
          op_next    = op[pick_id];
          a_next     = mux_a;
          b_next     = mux_b;
          ptr_next   = pick_id;
          cnt_next   = '0;
          grant_next = pick_onehot;
          busy_next  = 1'b1;
        end
      end
      ST_EXEC: begin
        if (op_reg == OP_MUL && cnt_reg != CNT_LAST) begin
          cnt_next = cnt_reg + 4'd1;
        end else begin
          state_next   = ST_DONE;
          done_next    = 1'b1;
          done_id_next = id_reg;
          result_next  = (op_reg == OP_MUL) ? prod : {{(DATA_W-1){1'b0}}, sum};
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign done_id = done_id_reg;

endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for alu_share_sched: per-scenario tasks plus a scoreboard that pairs
// each expected {id, result} with the next done pulse.
module tb_alu_share_sched;
  import alu_share_pkg::*;

  localparam int MUL_CYCLES = 2;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ-1:0]        op = '0;
  logic [N_REQ*DATA_W-1:0] a_bus = '0;
  logic [N_REQ*DATA_W-1:0] b_bus = '0;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic [2*DATA_W-1:0]     result;
  logic                    done;
  logic [ID_W-1:0]         done_id;

  int errors = 0;
  int checks = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  logic [17:0] exp_q[$];

  always #5 clock = ~clock;

  alu_share_sched #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .op      (op),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .grant   (grant),
    .busy    (busy),
    .result  (result),
    .done    (done),
    .done_id (done_id)
  );

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clock) begin
    logic [17:0] e;
    if (reset) begin
      if (grant != '0) grant_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done: got id=%0d result=%h, required no done", done_id, result);
        end else begin
          e = exp_q.pop_front();
          if ({done_id, result} !== e) begin
            errors++;
            $display("FAIL sb_result: got id=%0d result=%h, required id=%0d result=%h",
                     done_id, result, e[17:16], e[15:0]);
          end else begin
            $display("txn done id=%0d result=%h", done_id, result);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input int i, input logic o, input logic [7:0] a, input logic [7:0] b);
    op[i] = o;
    a_bus[i*8 +: 8] = a;
    b_bus[i*8 +: 8] = b;
  endtask

  function automatic logic [17:0] model(input logic [1:0] id, input logic o,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    if (o) r = 16'(a) * 16'(b);
    else   r = 16'(a) + 16'(b);
    return {id, r};
  endfunction

  // Waits (bounded) for a grant pulse; reports the number of negedges it took
  task automatic wait_grant(output logic [3:0] g, output int n);
    g = '0;
    n = 0;
    while (n < 20 && g == '0) begin
      tick();
      n++;
      if (grant != '0) g = grant;
    end
    if (g == '0) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout: got no grant in 20 cycles, required a grant");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (n < 20 && exp_q.size() != 0) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0;
    tick();
    tick();
    checks += 5;
    if (grant !== 4'b0)    begin errors++; $display("FAIL rst_grant: got %b, required 0000", grant); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    if (result !== 16'h0)  begin errors++; $display("FAIL rst_result: got %h, required 0000", result); end
    if (done_id !== 2'd0)  begin errors++; $display("FAIL rst_done_id: got %0d, required 0", done_id); end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_add();
    drive(0, OP_ADD, 8'hF0, 8'h20);
    req = 4'b0001;
    exp_q.push_back({2'd0, 16'h0110});
    tick();
    checks += 3;
    if (grant !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b, required 0001", grant); end
    if (busy !== 1'b1)     begin errors++; $display("FAIL add_busy_t1: got %b, required 1", busy); end
    if (done !== 1'b0)     begin errors++; $display("FAIL add_done_t1: got %b, required 0", done); end
    req = '0;
    tick();
    checks += 4;
    if (done !== 1'b1)      begin errors++; $display("FAIL add_done_t2: got %b, required 1", done); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL add_busy_t2: got %b, required 1", busy); end
    if (grant !== 4'b0)     begin errors++; $display("FAIL add_grant_t2: got %b, required 0000", grant); end
    if (result !== 16'h0110) begin errors++; $display("FAIL add_result: got %h, required 0110", result); end
    tick();
    checks += 3;
    if (busy !== 1'b0)       begin errors++; $display("FAIL add_busy_t3: got %b, required 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL add_done_t3: got %b, required 0", done); end
    if (result !== 16'h0110) begin errors++; $display("FAIL add_hold: got %h, required 0110", result); end
  endtask

  task automatic test_mul();
    drive(2, OP_MUL, 8'hFF, 8'hFF);
    req = 4'b0100;
    exp_q.push_back({2'd2, 16'hFE01});
    tick();
    checks += 2;
    if (grant !== 4'b0100) begin errors++; $display("FAIL mul_grant: got %b, required 0100", grant); end
    if (busy !== 1'b1)     begin errors++; $display("FAIL mul_busy_t1: got %b, required 1", busy); end
    req = '0;
    for (int c = 2; c <= MUL_CYCLES; c++) begin
      tick();
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_exec: got %b, required 1", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL mul_done_early: got %b, required 0", done); end
    end
    tick();
    checks += 3;
    if (done !== 1'b1)       begin errors++; $display("FAIL mul_done: got %b, required 1", done); end
    if (busy !== 1'b1)       begin errors++; $display("FAIL mul_busy_done: got %b, required 1", busy); end
    if (result !== 16'hFE01) begin errors++; $display("FAIL mul_result: got %h, required fe01", result); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] g;
    logic [3:0] eg;
    int n;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, OP_ADD, 8'(8'h80 + i*8'h11), 8'(8'h90 + i));
    for (int k = 0; k < 5; k++)
      exp_q.push_back(model(2'(order[k]), OP_ADD, 8'(8'h80 + order[k]*8'h11), 8'(8'h90 + order[k])));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, n);
      if (k == 4) req = '0;
      eg = 4'(1) << order[k];
      checks++;
      if (g !== eg) begin errors++; $display("FAIL rr_order%0d: got %b, required %b", k, g, eg); end
      if (k > 0) begin
        checks++;
        if (n != 3) begin errors++; $display("FAIL rr_gap%0d: got %0d cycles, required 3", k, n); end
      end
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    int n;
    drive(3, OP_ADD, 8'h7F, 8'h81);
    req = 4'b1000;
    exp_q.push_back({2'd3, 16'h0100});
    wait_grant(g, n);
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b, required 1000", g); end
    // Owner's inputs change mid-EXEC; the latched operands must win
    drive(3, OP_MUL, 8'h00, 8'h55);
    drive(0, OP_ADD, 8'h05, 8'h06);
    req = 4'b1001;
    exp_q.push_back({2'd0, 16'h000B});
    wait_grant(g, n);
    req = '0;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b, required 0001", g); end
    wait_drain();
  endtask

  task automatic test_abort();
    logic [3:0] g;
    int n;
    int d0;
    drive(1, OP_MUL, 8'hAB, 8'hCD);
    req = 4'b0010;
    wait_grant(g, n);
    req = '0;
    reset = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    if (grant !== 4'b0)   begin errors++; $display("FAIL abort_grant: got %b, required 0000", grant); end
    if (done !== 1'b0)    begin errors++; $display("FAIL abort_done: got %b, required 0", done); end
    if (result !== 16'h0) begin errors++; $display("FAIL abort_result: got %h, required 0000", result); end
    tick();
    reset = 1'b1;
    d0 = done_cnt;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL abort_stale: got %0d dones, required 0", done_cnt - d0); end
    drive(0, OP_ADD, 8'h01, 8'h02);
    drive(3, OP_ADD, 8'h03, 8'h04);
    req = 4'b1001;
    exp_q.push_back({2'd0, 16'h0003});
    wait_grant(g, n);
    req = '0;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL abort_ptr: got %b, required 0001", g); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] g;
    int n;
    int g0;
    int d0;
    g0 = grant_cnt;
    d0 = done_cnt;
    drive(0, OP_ADD, 8'h11, 8'h22);
    req = 4'b0001;
    exp_q.push_back({2'd0, 16'h0033});
    wait_grant(g, n);
    // Requester 2 pulses only while the datapath is busy
    drive(2, OP_MUL, 8'h09, 8'h09);
    req = 4'b0100;
    tick();
    req = '0;
    for (int c = 0; c < 6; c++) tick();
    wait_drain();
    checks += 2;
    if (grant_cnt - g0 != 1) begin errors++; $display("FAIL pulse_grants: got %0d, required 1", grant_cnt - g0); end
    if (done_cnt - d0 != grant_cnt - g0) begin
      errors++;
      $display("FAIL pulse_balance: got %0d dones, required %0d", done_cnt - d0, grant_cnt - g0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_round_robin();
    test_wrap();
    test_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
